// File: rtl/strip_pkg.sv
// Constants and helpers shared by the strip-tracking front end, the placement pipe
// and the write-back stage.
package strip_pkg;

  localparam int ID_W_DEF      = 4;
  localparam int WID_W_DEF     = 8;
  localparam int STRIP_CAP_DEF = 128;
  localparam int MAX_CAND      = 8;

  // Candidate k occupies bits [k*WID_W_DEF +: WID_W_DEF] of a packed width bus.
  function automatic logic [MAX_CAND*WID_W_DEF-1:0] pack_width(
    input logic [MAX_CAND*WID_W_DEF-1:0] bus,
    input int                            k,
    input logic [WID_W_DEF-1:0]          w
  );
    logic [MAX_CAND*WID_W_DEF-1:0] r;
    r = bus;
    r[k*WID_W_DEF +: WID_W_DEF] = w;
    return r;
  endfunction

endpackage

// File: rtl/strip_min_select.sv
// Combinational selection of the smallest (or largest) occupied width among N
// candidates, returning its index, ID and width.
module strip_min_select #(
  parameter int N        = 3,
  parameter int ID_W     = 4,
  parameter int WID_W    = 8,
  parameter bit FIND_MAX = 1'b0,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic [N*ID_W-1:0]  ids,
  input  logic [N*WID_W-1:0] widths,
  output logic [IDX_W-1:0]   sel_idx,
  output logic [ID_W-1:0]    sel_id,
  output logic [WID_W-1:0]   sel_width
);

  logic [WID_W-1:0] wk;
  logic             better;

  // Strict compare: a later candidate only wins on a strictly better width,
  // so ties resolve to the lowest index.
  always_comb begin
    sel_idx   = '0;
    sel_width = widths[WID_W-1:0];
    wk        = '0;
    better    = 1'b0;
    for (int k = 1; k < N; k++) begin
      wk     = widths[k*WID_W +: WID_W];
      better = FIND_MAX ? (wk > sel_width) : (wk < sel_width);
      if (better) begin
        sel_idx   = IDX_W'(k);
        sel_width = wk;
      end
    end
  end

  assign sel_id = ids[sel_idx*ID_W +: ID_W];

endmodule

// File: rtl/strip_min_strike_pipe.sv
// Two-stage strip placement: pick least-occupied candidate, then test fit against
// STRIP_CAP and track consecutive misses with a saturating strike counter.
module strip_min_strike_pipe
  import strip_pkg::*;
#(
  parameter int NUM_CAND     = 3,
  parameter int ID_W         = ID_W_DEF,
  parameter int WID_W        = WID_W_DEF,
  parameter int STRIP_CAP    = STRIP_CAP_DEF,
  parameter int CNT_W        = 4,
  parameter int STRIKE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [NUM_CAND*ID_W-1:0]  strip_id,
  input  logic [NUM_CAND*WID_W-1:0] occupied_width,
  input  logic [WID_W-1:0]          width_in,
  input  logic                      strike_clr,
  output logic                      out_valid,
  output logic [ID_W-1:0]           min_strip_id,
  output logic [WID_W-1:0]          min_strip_width,
  output logic                      strike_flag,
  output logic [WID_W-1:0]          new_strip_width,
  output logic [CNT_W-1:0]          strike_count,
  output logic                      strike_limit_hit
);

  localparam int            IDX_W = $clog2(NUM_CAND);
  localparam logic [WID_W:0] CAP  = (WID_W+1)'(STRIP_CAP);

  logic [IDX_W-1:0] sel_idx_unused;
  logic [ID_W-1:0]  sel_id;
  logic [WID_W-1:0] sel_width;

  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;
  logic [WID_W-1:0] s1_width;
  logic [WID_W-1:0] s1_win;

  logic [WID_W:0]   sum;
  logic             strike;

  strip_min_select #(
    .N       (NUM_CAND),
    .ID_W    (ID_W),
    .WID_W   (WID_W),
    .FIND_MAX(1'b0)
  ) u_sel (
    .ids      (strip_id),
    .widths   (occupied_width),
    .sel_idx  (sel_idx_unused),
    .sel_id   (sel_id),
    .sel_width(sel_width)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_width <= '0;
      s1_win   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_id    <= sel_id;
        s1_width <= sel_width;
        s1_win   <= width_in;
      end
    end
  end

  // One extra bit so the sum can never wrap below the cap.
  assign sum    = {1'b0, s1_width} + {1'b0, s1_win};
  assign strike = (sum > CAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      min_strip_id    <= '0;
      min_strip_width <= '0;
      strike_flag     <= 1'b0;
      new_strip_width <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        min_strip_id    <= s1_id;
        min_strip_width <= s1_width;
        strike_flag     <= strike;
        new_strip_width <= strike ? s1_width : sum[WID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      strike_count <= '0;
    else if (strike_clr)
      strike_count <= '0;
    else if (s1_valid) begin
      if (!strike)
        strike_count <= '0;
      else if (strike_count != '1)
        strike_count <= strike_count + 1'b1;
    end
  end

  assign strike_limit_hit = (strike_count >= CNT_W'(STRIKE_LIMIT));

endmodule

// File: tb/tb_strip_min_strike_pipe.sv
// Directed bench for strip_min_strike_pipe: selection, fit/strike, counter
// saturation and clear, bubbles, async reset, and an 8-candidate instance.
module tb_strip_min_strike_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] strip_id = '0;
  logic [23:0] occupied_width = '0;
  logic [7:0]  width_in = '0;
  logic        strike_clr = 1'b0;
  logic        out_valid;
  logic [3:0]  min_strip_id;
  logic [7:0]  min_strip_width;
  logic        strike_flag;
  logic [7:0]  new_strip_width;
  logic [3:0]  strike_count;
  logic        strike_limit_hit;

  logic        v8 = 1'b0;
  logic [31:0] ids8 = '0;
  logic [63:0] occ8 = '0;
  logic [7:0]  win8 = '0;
  logic        clr8 = 1'b0;
  logic        ov8;
  logic [3:0]  id8;
  logic [7:0]  mw8;
  logic        sf8;
  logic [7:0]  nw8;
  logic [3:0]  cnt8;
  logic        lim8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  strip_min_strike_pipe #(.NUM_CAND(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .strip_id(strip_id),
    .occupied_width(occupied_width), .width_in(width_in), .strike_clr(strike_clr),
    .out_valid(out_valid), .min_strip_id(min_strip_id), .min_strip_width(min_strip_width),
    .strike_flag(strike_flag), .new_strip_width(new_strip_width),
    .strike_count(strike_count), .strike_limit_hit(strike_limit_hit)
  );

  strip_min_strike_pipe #(.NUM_CAND(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .strip_id(ids8),
    .occupied_width(occ8), .width_in(win8), .strike_clr(clr8),
    .out_valid(ov8), .min_strip_id(id8), .min_strip_width(mw8),
    .strike_flag(sf8), .new_strip_width(nw8),
    .strike_count(cnt8), .strike_limit_hit(lim8)
  );

  // Present one cycle of stimulus at a negedge and advance past the next posedge.
  task automatic drive(input logic v, input logic [3:0] i0, i1, i2,
                       input logic [7:0] w0, w1, w2, input logic [7:0] win);
    in_valid       = v;
    strip_id       = {i2, i1, i0};
    occupied_width = {w2, w1, w0};
    width_in       = win;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0d want 0", out_valid); end
    n_cmp++; if (strike_count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", strike_count); end
    n_cmp++; if (new_strip_width !== 8'd0) begin n_err++; $display("FAIL rst_new: got %0d want 0", new_strip_width); end
    n_cmp++; if (strike_limit_hit !== 1'b0) begin n_err++; $display("FAIL rst_limit: got %0d want 0", strike_limit_hit); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    drive(1'b1, 4'd1, 4'd2, 4'd3, 8'd40, 8'd20, 8'd60, 8'd30);
    idle();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0d want 1", out_valid); end
    n_cmp++; if (min_strip_id !== 4'd2) begin n_err++; $display("FAIL basic_id: got %0d want 2", min_strip_id); end
    n_cmp++; if (min_strip_width !== 8'd20) begin n_err++; $display("FAIL basic_min: got %0d want 20", min_strip_width); end
    n_cmp++; if (strike_flag !== 1'b0) begin n_err++; $display("FAIL basic_strike: got %0d want 0", strike_flag); end
    n_cmp++; if (new_strip_width !== 8'd50) begin n_err++; $display("FAIL basic_new: got %0d want 50", new_strip_width); end
    n_cmp++; if (strike_count !== 4'd0) begin n_err++; $display("FAIL basic_count: got %0d want 0", strike_count); end
  endtask

  task automatic test_boundary();
    drive(1'b1, 4'd4, 4'd5, 4'd6, 8'd50, 8'd50, 8'd50, 8'd0);
    idle();
    n_cmp++; if (min_strip_id !== 4'd4) begin n_err++; $display("FAIL tie_id: got %0d want 4", min_strip_id); end
    n_cmp++; if (strike_flag !== 1'b0) begin n_err++; $display("FAIL zero_win_strike: got %0d want 0", strike_flag); end
    n_cmp++; if (new_strip_width !== 8'd50) begin n_err++; $display("FAIL zero_win_new: got %0d want 50", new_strip_width); end
    // Minimum already above the cap: even a zero-width program strikes.
    drive(1'b1, 4'd7, 4'd8, 4'd9, 8'd200, 8'd210, 8'd220, 8'd0);
    idle();
    n_cmp++; if (strike_flag !== 1'b1) begin n_err++; $display("FAIL overcap_strike: got %0d want 1", strike_flag); end
    n_cmp++; if (new_strip_width !== 8'd200) begin n_err++; $display("FAIL overcap_new: got %0d want 200", new_strip_width); end
    n_cmp++; if (strike_count !== 4'd1) begin n_err++; $display("FAIL overcap_count: got %0d want 1", strike_count); end
  endtask

  task automatic test_strike();
    drive(1'b1, 4'd5, 4'd6, 4'd7, 8'd100, 8'd100, 8'd110, 8'd29);
    idle();
    n_cmp++; if (min_strip_id !== 4'd5) begin n_err++; $display("FAIL strike_id: got %0d want 5", min_strip_id); end
    n_cmp++; if (strike_flag !== 1'b1) begin n_err++; $display("FAIL strike_flag: got %0d want 1", strike_flag); end
    n_cmp++; if (new_strip_width !== 8'd100) begin n_err++; $display("FAIL strike_new: got %0d want 100", new_strip_width); end
    n_cmp++; if (strike_count !== 4'd2) begin n_err++; $display("FAIL strike_count: got %0d want 2", strike_count); end
    drive(1'b1, 4'd5, 4'd6, 4'd7, 8'd100, 8'd100, 8'd110, 8'd28);
    idle();
    n_cmp++; if (strike_flag !== 1'b0) begin n_err++; $display("FAIL cap_eq_strike: got %0d want 0", strike_flag); end
    n_cmp++; if (new_strip_width !== 8'd128) begin n_err++; $display("FAIL cap_eq_new: got %0d want 128", new_strip_width); end
    n_cmp++; if (strike_count !== 4'd0) begin n_err++; $display("FAIL cap_eq_count: got %0d want 0", strike_count); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 10; c++) begin
      if (c < 10) drive(1'b1, 4'd1, 4'd2, 4'd3, 8'd120, 8'd125, 8'd127, 8'd20);
      else        idle();
      if (c >= 1) begin
        n_cmp++; if (strike_count !== 4'(c)) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want %0d", c, strike_count, c); end
        n_cmp++; if (strike_limit_hit !== (c >= 8)) begin n_err++; $display("FAIL b2b_limit[%0d]: got %0d want %0d", c, strike_limit_hit, c >= 8); end
      end
    end
    drive(1'b1, 4'd1, 4'd2, 4'd3, 8'd40, 8'd20, 8'd60, 8'd30);
    idle();
    n_cmp++; if (strike_count !== 4'd0) begin n_err++; $display("FAIL b2b_reset_count: got %0d want 0", strike_count); end
    n_cmp++; if (strike_limit_hit !== 1'b0) begin n_err++; $display("FAIL b2b_reset_limit: got %0d want 0", strike_limit_hit); end
    for (int c = 0; c < 17; c++) drive(1'b1, 4'd1, 4'd2, 4'd3, 8'd120, 8'd125, 8'd127, 8'd20);
    idle();
    n_cmp++; if (strike_count !== 4'd15) begin n_err++; $display("FAIL sat_count: got %0d want 15", strike_count); end
    n_cmp++; if (strike_limit_hit !== 1'b1) begin n_err++; $display("FAIL sat_limit: got %0d want 1", strike_limit_hit); end
  endtask

  task automatic test_clr();
    drive(1'b1, 4'd1, 4'd2, 4'd3, 8'd120, 8'd125, 8'd127, 8'd20);
    in_valid   = 1'b0;
    strike_clr = 1'b1;
    @(negedge clk);
    strike_clr = 1'b0;
    n_cmp++; if (strike_flag !== 1'b1) begin n_err++; $display("FAIL clr_flag: got %0d want 1", strike_flag); end
    n_cmp++; if (strike_count !== 4'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", strike_count); end
    n_cmp++; if (strike_limit_hit !== 1'b0) begin n_err++; $display("FAIL clr_limit: got %0d want 0", strike_limit_hit); end
  endtask

  task automatic test_bubbles();
    logic [7:0] pv;
    logic       ev;
    logic [7:0] exp_w;
    logic [3:0] exp_id;
    logic [3:0] exp_cnt;
    pv      = 8'b0011_0101;
    exp_w   = '0;
    exp_id  = '0;
    exp_cnt = '0;
    for (int c = 0; c <= 8; c++) begin
      // Candidate 0 is always the minimum; sum = 10c+130 always strikes.
      drive((c < 8) ? pv[c] : 1'b0, 4'(c), 4'd14, 4'd15, 8'(10*c + 5), 8'd200, 8'd200, 8'd125);
      if (c >= 1) begin
        ev = pv[c-1];
        if (ev) begin
          exp_cnt = exp_cnt + 1'b1;
          exp_w   = 8'(10*(c-1) + 5);
          exp_id  = 4'(c-1);
        end
        n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL bub_valid[%0d]: got %0d want %0d", c, out_valid, ev); end
        n_cmp++; if (min_strip_id !== exp_id) begin n_err++; $display("FAIL bub_id[%0d]: got %0d want %0d", c, min_strip_id, exp_id); end
        n_cmp++; if (new_strip_width !== exp_w) begin n_err++; $display("FAIL bub_new[%0d]: got %0d want %0d", c, new_strip_width, exp_w); end
        n_cmp++; if (strike_count !== exp_cnt) begin n_err++; $display("FAIL bub_count[%0d]: got %0d want %0d", c, strike_count, exp_cnt); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 4'd1, 4'd2, 4'd3, 8'd120, 8'd125, 8'd127, 8'd20);
    drive(1'b1, 4'd4, 4'd5, 4'd6, 8'd90, 8'd125, 8'd127, 8'd50);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %0d want 0", out_valid); end
    n_cmp++; if (strike_count !== 4'd0) begin n_err++; $display("FAIL mrst_count: got %0d want 0", strike_count); end
    n_cmp++; if ({min_strip_id, min_strip_width, strike_flag, new_strip_width} !== '0) begin
      n_err++; $display("FAIL mrst_data: got id %0d min %0d flag %0d new %0d want all 0",
                        min_strip_id, min_strip_width, strike_flag, new_strip_width); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_flush[%0d]: got %0d want 0", c, out_valid); end
    end
    drive(1'b1, 4'd1, 4'd2, 4'd3, 8'd120, 8'd125, 8'd127, 8'd20);
    idle();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mrst_new_valid: got %0d want 1", out_valid); end
    n_cmp++; if (strike_count !== 4'd1) begin n_err++; $display("FAIL mrst_new_count: got %0d want 1", strike_count); end
  endtask

  task automatic test_cand8();
    ids8 = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    occ8 = {8'd20, 8'd46, 8'd45, 8'd44, 8'd43, 8'd42, 8'd41, 8'd40};
    win8 = 8'd30;
    v8   = 1'b1;
    @(negedge clk);
    v8   = 1'b0;
    @(negedge clk);
    n_cmp++; if (ov8 !== 1'b1) begin n_err++; $display("FAIL c8_valid: got %0d want 1", ov8); end
    n_cmp++; if (id8 !== 4'd8) begin n_err++; $display("FAIL c8_id: got %0d want 8", id8); end
    n_cmp++; if (mw8 !== 8'd20) begin n_err++; $display("FAIL c8_min: got %0d want 20", mw8); end
    n_cmp++; if (sf8 !== 1'b0) begin n_err++; $display("FAIL c8_strike: got %0d want 0", sf8); end
    n_cmp++; if (nw8 !== 8'd50) begin n_err++; $display("FAIL c8_new: got %0d want 50", nw8); end
    n_cmp++; if (cnt8 !== 4'd0 || lim8 !== 1'b0) begin n_err++; $display("FAIL c8_count: got %0d/%0d want 0/0", cnt8, lim8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_strike();
    test_back_to_back();
    test_clr();
    test_bubbles();
    test_reset_midstream();
    test_cand8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
